// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: op codes, sequencer states and expected truth tables indexed by {A,B}.
package gate_seq_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_e;
endpackage

// File: rtl/gate_expect_lut.sv
// gate_expect_lut: maps a gate op code to its expected truth table and flags illegal codes.
module gate_expect_lut
  import gate_seq_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [3:0] tt_o,
  output logic       illegal_o
);
  always_comb begin
    tt_o = 4'h0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:  tt_o = TT_AND;
      OP_NAND: tt_o = TT_NAND;
      OP_OR:   tt_o = TT_OR;
      OP_NOR:  tt_o = TT_NOR;
      OP_XOR:  tt_o = TT_XOR;
      OP_XNOR: tt_o = TT_XNOR;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: walks a 2-input gate through its truth table and checks each
// vector's output on the last hold cycle against the selected gate type.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op_sel,
  input  logic       dut_x,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic       err,
  output logic [1:0] vec_idx
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  state_e state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [3:0] fail_q, fail_d;
  logic err_q, err_d, pass_q, pass_d;
  logic [3:0] tt;
  logic illegal;
  // In IDLE the LUT judges the requested op; afterwards it serves the latched one.
  gate_expect_lut u_lut (
    .op_i      (state_q == IDLE ? op_sel : op_q),
    .tt_o      (tt),
    .illegal_o (illegal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      fail_q  <= 4'h0;
      err_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    op_d = op_q;
    fail_d = fail_q;
    err_d = err_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (start) begin
        pass_d = 1'b0;
        if (illegal) begin
          err_d = 1'b1;
          fail_d = 4'hF;
          state_d = DONE;
        end else begin
          op_d = op_sel;
          fail_d = 4'h0;
          err_d = 1'b0;
          vec_d = 2'd0;
          cnt_d = '0;
          state_d = APPLY;
        end
      end
      APPLY: if (cnt_q == LAST) begin
        // dut_x still reflects the current vector; the next vector appears after this edge.
        fail_d[vec_q] = dut_x != tt[vec_q];
        cnt_d = '0;
        if (vec_q == 2'd3) begin
          pass_d = fail_d == 4'h0;
          state_d = DONE;
        end else begin
          vec_d = vec_q + 2'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign dut_a    = state_q == APPLY && vec_q[1];
  assign dut_b    = state_q == APPLY && vec_q[0];
  assign vec_idx  = state_q == APPLY ? vec_q : 2'd0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign pass     = pass_q;
  assign fail_vec = fail_q;
  assign err      = err_q;
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: drives modelled gates (correct, wrong, stuck) into the sequencer
// and checks the vector walk, timing and verdicts against a boolean reference.
module tb_gate_truth_sequencer;
  localparam int H = 10;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dut_x;
  logic [2:0] op_sel = 3'd0;
  logic dut_a, dut_b, busy, done, pass, err;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;
  int kind_v = 1;
  int checks = 0, errors = 0;

  gate_truth_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .dut_x(dut_x),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .err(err), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;

  // kinds 0..5 are real gates in op_sel order, 6 is stuck-at-0, 7 stuck-at-1
  function automatic logic gate_eval(input int k, input logic a, input logic b);
    case (k)
      0: return a & b;
      1: return ~(a & b);
      2: return a | b;
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb dut_x = gate_eval(kind_v, dut_a, dut_b);

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({busy, done, pass, err, dut_a, dut_b} !== 6'b0 || fail_vec !== 4'h0 || vec_idx !== 2'd0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b pass=%b err=%b a=%b b=%b fail_vec=%h idx=%0d, want all 0",
               tag, busy, done, pass, err, dut_a, dut_b, fail_vec, vec_idx);
    end
  endtask

  task automatic run(input logic [2:0] op, input int kind, input int restart_c, input int switch_c,
                     input bit start_at_done, input string tag);
    bit ill;
    logic [3:0] ef;
    int ed;
    logic [1:0] ev;
    ill = op > 3'd5;
    ef = 4'hF;
    if (!ill)
      for (int i = 0; i < 4; i++) ef[i] = gate_eval(kind, i[1], i[0]) != gate_eval(int'(op), i[1], i[0]);
    ed = ill ? 1 : 4 * H + 1;
    kind_v = kind;
    @(negedge clk);
    start = 1'b1;
    op_sel = op;
    for (int c = 1; c <= ed + 1; c++) begin
      @(negedge clk);
      start = (c == restart_c) || (start_at_done && c == ed);
      if (c == switch_c) op_sel = 3'd2;
      ev = (ill || c >= ed) ? 2'd0 : 2'((c - 1) / H);
      if (c < ed) begin
        checks++;
        if ({busy, done} !== 2'b10 || {dut_a, dut_b} !== ev || vec_idx !== ev) begin
          errors++;
          $display("FAIL %s apply c=%0d: got busy=%b done=%b ab=%b%b idx=%0d, want busy=1 done=0 ab=%b idx=%0d",
                   tag, c, busy, done, dut_a, dut_b, vec_idx, ev, ev);
        end
      end else begin
        checks++;
        if ({busy, done} !== (c == ed ? 2'b11 : 2'b00) || {dut_a, dut_b} !== 2'b00) begin
          errors++;
          $display("FAIL %s end c=%0d: got busy=%b done=%b ab=%b%b, want busy=done=%b ab=00",
                   tag, c, busy, done, dut_a, dut_b, c == ed);
        end
        checks++;
        if (pass !== (ef == 4'h0) || fail_vec !== ef || err !== ill) begin
          errors++;
          $display("FAIL %s result c=%0d: got pass=%b fail_vec=%b err=%b, want pass=%b fail_vec=%b err=%b",
                   tag, c, pass, fail_vec, err, ef == 4'h0, ef, ill);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 check_idle_zero("reset_asserted");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_released");
  endtask

  task automatic test_nand_pass();
    run(3'd1, 1, -1, -1, 0, "nand_pass");
  endtask

  task automatic test_wrong_gate();
    run(3'd1, 0, -1, -1, 0, "and_as_nand");
  endtask

  task automatic test_stuck();
    run(3'd1, 7, -1, -1, 0, "nand_stuck1");
    run(3'd0, 6, -1, -1, 0, "and_stuck0");
  endtask

  task automatic test_illegal();
    run(3'd6, 1, -1, -1, 0, "illegal6");
    run(3'd7, 1, -1, -1, 1, "illegal7");
  endtask

  task automatic test_ignored_inputs();
    run(3'd1, 1, 15, 20, 0, "nand_ignored");
  endtask

  task automatic test_back_to_back();
    run(3'd4, 4, -1, -1, 1, "xor_b2b");
    run(3'd5, 4, -1, -1, 0, "xnor_on_xor");
    run(3'd3, 3, -1, -1, 0, "nor_pass");
  endtask

  task automatic test_mid_reset();
    kind_v = 1;
    @(negedge clk);
    start = 1'b1;
    op_sel = 3'd1;
    for (int c = 1; c < 25; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_zero("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_hold: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    run(3'd1, 1, -1, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), -1, -1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nand_pass();
    test_wrong_gate();
    test_stuck();
    test_illegal();
    test_ignored_inputs();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
